// File: rtl/mmram_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mmram_issue_pkg
// Brief   : Shared constants, field offsets and state/decision encodings for
//           the MMRAM issue stage.
// Revision: 1.0 - initial release
// ============================================================================
package mmram_issue_pkg;

    localparam int MMRAM_ADDR_LENGTH = 6;
    localparam int MMRAM_PACKET_SIZE = 38;

    // Token field offsets
    localparam int DEST_LSB = 20;
    localparam int LR_BIT   = 19;
    localparam int PAIR_BIT = 18;

    // Issue FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_REQ    = 2'd2,
        ST_REL    = 2'd3
    } state_e;

    // Per-token decision taken in LOOKUP, remembered for the table commit
    typedef enum logic [1:0] {
        OP_CONST = 2'd0,
        OP_STORE = 2'd1,
        OP_FIRE  = 2'd2
    } op_e;

endpackage
`default_nettype wire

// File: rtl/mmram_issue_ack_sync.sv
`default_nettype none
// ============================================================================
// Module  : mmram_issue_ack_sync
// Brief   : Two-flop synchronizer bringing the MMRAM Ack into the CP domain.
// Revision: 1.0 - initial release
// ============================================================================
module mmram_issue_ack_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous acknowledge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/mmram_issue.sv
`default_nettype none
// ============================================================================
// Module  : mmram_issue
// Brief   : Issue stage in front of the matching memory. Classifies each token
//           (store / fire with partner / constant), keeps the presence/side
//           table and drives the MMRAM four-phase Send/Ack handshake.
// Revision: 1.0 - initial release
// ============================================================================
module mmram_issue
    import mmram_issue_pkg::*;
#(
    parameter int ADDR_LENGTH = MMRAM_ADDR_LENGTH,
    parameter int PKT_W       = MMRAM_PACKET_SIZE
) (
    input  logic                   CP,
    input  logic                   MR_N,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [PKT_W-1:0]       IN_PACKET,
    output logic                   Send_out,
    input  logic                   Ack_in,
    output logic [PKT_W-1:0]       PACKET_OUT,
    output logic                   WR_E,
    output logic [ADDR_LENGTH-1:0] ADDR,
    output logic                   DEL,
    output logic [ADDR_LENGTH:0]   OCC,
    output logic                   ERR
);

    localparam int DEPTH = 2 ** ADDR_LENGTH;
    localparam logic [ADDR_LENGTH:0] C_OCC_ONE = {{ADDR_LENGTH{1'b0}}, 1'b1};

    // Internal reset: asserts with MR_N, releases synchronously to CP
    logic r_rst_meta;
    logic r_rst_n;

    state_e                 r_state;
    state_e                 w_next_state;
    logic [PKT_W-1:0]       r_hold;
    op_e                    r_op;
    op_e                    w_op;
    logic                   w_collide;
    logic                   w_commit;
    logic                   r_send;
    logic                   w_send_next;
    logic                   w_ack;
    logic [ADDR_LENGTH-1:0] w_a;
    logic                   w_hit;
    logic                   w_same_side;
    logic [DEPTH-1:0]       r_present;
    logic [DEPTH-1:0]       r_side;
    logic [ADDR_LENGTH:0]   r_occ;
    logic                   r_err;
    logic [PKT_W-1:0]       r_pkt_out;
    logic [ADDR_LENGTH-1:0] r_addr;
    logic                   r_wr_e;
    logic                   r_del;

    // Reset synchronizer: async assert, release after two CP edges
    always_ff @(posedge CP or negedge MR_N) begin
        if (!MR_N) begin
            r_rst_meta <= 1'b0;
            r_rst_n    <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_n    <= r_rst_meta;
        end
    end

    mmram_issue_ack_sync u_ack_sync (
        .i_clk   (CP),
        .i_rst_n (r_rst_n),
        .i_async (Ack_in),
        .o_sync  (w_ack)
    );

    assign w_a         = r_hold[DEST_LSB +: ADDR_LENGTH];
    assign w_hit       = r_present[w_a];
    assign w_same_side = (r_side[w_a] == r_hold[LR_BIT]);

    // Token classification and next-state / handshake request logic
    always_comb begin
        w_next_state = r_state;
        w_op         = OP_CONST;
        w_collide    = 1'b0;
        w_commit     = 1'b0;
        w_send_next  = 1'b0;

        if (!r_hold[PAIR_BIT]) begin
            w_op = OP_CONST;
        end else if (!w_hit) begin
            w_op = OP_STORE;
        end else if (!w_same_side) begin
            w_op = OP_FIRE;
        end else begin
            w_collide = 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (IN_VALID) begin
                    w_next_state = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                w_next_state = w_collide ? ST_IDLE : ST_REQ;
            end
            ST_REQ: begin
                // Only an Ack seen while our request is up completes the phase;
                // the request never rises while the synchronized Ack is high.
                if (r_send && w_ack) begin
                    w_next_state = ST_REL;
                    w_commit     = 1'b1;
                end else begin
                    w_send_next = r_send | ~w_ack;
                end
            end
            ST_REL: begin
                if (!w_ack) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // FSM state, hold register, request flop and bundled-data outputs
    always_ff @(posedge CP or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_state   <= ST_IDLE;
            r_hold    <= '0;
            r_op      <= OP_CONST;
            r_send    <= 1'b0;
            r_err     <= 1'b0;
            r_pkt_out <= '0;
            r_addr    <= '0;
            r_wr_e    <= 1'b0;
            r_del     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_send  <= w_send_next;
            if (r_state == ST_IDLE && IN_VALID) begin
                r_hold <= IN_PACKET;
            end
            if (r_state == ST_LOOKUP) begin
                if (w_collide) begin
                    r_err <= 1'b1;
                end else begin
                    r_pkt_out <= r_hold;
                    r_addr    <= w_a;
                    r_wr_e    <= (w_op == OP_STORE);
                    r_del     <= (w_op == OP_STORE);
                    r_op      <= w_op;
                end
            end
        end
    end

    // Presence/side table and occupancy, committed on the edge leaving REQ
    always_ff @(posedge CP or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_present <= '0;
            r_side    <= '0;
            r_occ     <= '0;
        end else if (w_commit) begin
            case (r_op)
                OP_STORE: begin
                    r_present[w_a] <= 1'b1;
                    r_side[w_a]    <= r_hold[LR_BIT];
                    r_occ          <= r_occ + C_OCC_ONE;
                end
                OP_FIRE: begin
                    r_present[w_a] <= 1'b0;
                    r_occ          <= r_occ - C_OCC_ONE;
                end
                default: begin
                end
            endcase
        end
    end

    assign IN_READY   = (r_state == ST_IDLE);
    assign Send_out   = r_send;
    assign PACKET_OUT = r_pkt_out;
    assign ADDR       = r_addr;
    assign WR_E       = r_wr_e;
    assign DEL        = r_del;
    assign OCC        = r_occ;
    assign ERR        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mmram_issue.sv
`default_nettype none
// ============================================================================
// Module  : tb_mmram_issue
// Brief   : Self-checking bench for mmram_issue with a randomized-delay Ack
//           responder and a table-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mmram_issue;

    logic        CP;
    logic        MR_N;
    logic        IN_VALID;
    logic        IN_READY;
    logic [37:0] IN_PACKET;
    logic        Send_out;
    logic        Ack_in;
    logic [37:0] PACKET_OUT;
    logic        WR_E;
    logic [5:0]  ADDR;
    logic        DEL;
    logic [6:0]  OCC;
    logic        ERR;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: which addresses hold a waiting operand and on which side
    bit m_present [64];
    bit m_side    [64];
    int m_occ;
    bit m_err;

    mmram_issue dut (
        .CP         (CP),
        .MR_N       (MR_N),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .IN_PACKET  (IN_PACKET),
        .Send_out   (Send_out),
        .Ack_in     (Ack_in),
        .PACKET_OUT (PACKET_OUT),
        .WR_E       (WR_E),
        .ADDR       (ADDR),
        .DEL        (DEL),
        .OCC        (OCC),
        .ERR        (ERR)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [37:0] mk(input logic [6:0] dest, input logic lr,
                                       input logic pair, input logic [15:0] data);
        mk = {11'h0, dest, lr, pair, 2'b00, data};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) begin
            m_present[i] = 1'b0;
            m_side[i]    = 1'b0;
        end
        m_occ = 0;
        m_err = 1'b0;
    endtask

    // Four-phase responder: Ack follows Send after 1..6 edges
    initial begin
        Ack_in = 1'b0;
        forever begin
            @(negedge CP);
            if (Send_out !== Ack_in) begin
                @(posedge CP);
                repeat ($urandom_range(0, 5)) @(posedge CP);
                #1 Ack_in = Send_out;
            end
        end
    end

    // Handshake ordering and bundled-data stability monitor
    initial begin
        logic        ack_h [3];
        logic        prev_send;
        logic [37:0] prev_pkt;
        ack_h[0] = 1'b0; ack_h[1] = 1'b0; ack_h[2] = 1'b0;
        prev_send = 1'b0;
        prev_pkt  = '0;
        forever begin
            @(negedge CP);
            if (MR_N === 1'b1) begin
                if (Send_out && !prev_send) begin
                    // synchronized Ack at the rising edge is Ack_in from two edges earlier
                    check("send_rise_ack", {63'd0, ack_h[2]}, 64'd0);
                    check("pkt_before_send", {26'd0, PACKET_OUT}, {26'd0, prev_pkt});
                end else if (Send_out) begin
                    check("pkt_stable", {26'd0, PACKET_OUT}, {26'd0, prev_pkt});
                end
            end
            ack_h[2]  = ack_h[1];
            ack_h[1]  = ack_h[0];
            ack_h[0]  = Ack_in;
            prev_send = Send_out;
            prev_pkt  = PACKET_OUT;
        end
    end

    // Offer one token, check its decision and handshake, update the model
    task automatic send_token(input logic [37:0] pkt);
        int  a;
        bit  lr;
        bit  pair;
        bit  collide;
        bit  store;
        bit  fire;
        int  n;
        a       = int'(pkt[25:20]);
        lr      = pkt[19];
        pair    = pkt[18];
        store   = pair && !m_present[a];
        fire    = pair && m_present[a] && (m_side[a] != lr);
        collide = pair && m_present[a] && (m_side[a] == lr);

        n = 0;
        @(negedge CP);
        while (IN_READY !== 1'b1 && n < 100) begin
            @(negedge CP);
            n++;
        end
        if (IN_READY !== 1'b1) check("ready_timeout", {63'd0, IN_READY}, 64'd1);
        IN_VALID  = 1'b1;
        IN_PACKET = pkt;
        @(posedge CP);
        #1 IN_VALID = 1'b0;
        IN_PACKET = {$urandom, $urandom};
        @(negedge CP);
        check("busy_in_lookup", {63'd0, IN_READY}, 64'd0);
        @(negedge CP);
        if (collide) begin
            m_err = 1'b1;
            check("coll_err", {63'd0, ERR}, 64'd1);
            check("coll_ready", {63'd0, IN_READY}, 64'd1);
            check("coll_nosend", {63'd0, Send_out}, 64'd0);
            @(negedge CP);
            check("coll_nosend2", {63'd0, Send_out}, 64'd0);
        end else begin
            check("wr_e", {63'd0, WR_E}, {63'd0, store});
            check("del", {63'd0, DEL}, {63'd0, store});
            check("addr", {58'd0, ADDR}, 64'(a));
            check("pkt_out", {26'd0, PACKET_OUT}, {26'd0, pkt});
            check("send_low_lookup", {63'd0, Send_out}, 64'd0);
            @(negedge CP);
            check("send_rise", {63'd0, Send_out}, 64'd1);
            n = 0;
            while (IN_READY !== 1'b1 && n < 60) begin
                @(negedge CP);
                n++;
            end
            check("hs_done", {63'd0, IN_READY}, 64'd1);
            if (store) begin
                m_present[a] = 1'b1;
                m_side[a]    = lr;
                m_occ++;
            end else if (fire) begin
                m_present[a] = 1'b0;
                m_occ--;
            end
        end
        check("occ", {57'd0, OCC}, 64'(m_occ));
        check("err", {63'd0, ERR}, {63'd0, m_err});
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        logic [37:0] pkt;
        MR_N      = 1'b0;
        IN_VALID  = 1'b0;
        IN_PACKET = '0;
        model_clear();
        repeat (3) @(negedge CP);
        check("rst_ready", {63'd0, IN_READY}, 64'd1);
        check("rst_send", {63'd0, Send_out}, 64'd0);
        check("rst_pkt", {26'd0, PACKET_OUT}, 64'd0);
        check("rst_addr", {58'd0, ADDR}, 64'd0);
        check("rst_wre_del", {62'd0, WR_E, DEL}, 64'd0);
        check("rst_occ_err", {56'd0, OCC, ERR}, 64'd0);
        MR_N = 1'b1;
        repeat (4) @(negedge CP);

        // Store then fire at address 5
        send_token(mk(7'h05, 1'b0, 1'b1, 16'hA5A5));
        send_token(mk(7'h05, 1'b1, 1'b1, 16'h5A5A));
        // Constant operand at the top address
        send_token(mk(7'h3F, 1'b0, 1'b0, 16'h1234));
        // Same-side collision at 0x10
        send_token(mk(7'h10, 1'b0, 1'b1, 16'h0001));
        send_token(mk(7'h10, 1'b0, 1'b1, 16'h0002));

        // Reset during REQ: outputs and table drop asynchronously
        @(negedge CP);
        IN_VALID  = 1'b1;
        IN_PACKET = mk(7'h20, 1'b0, 1'b1, 16'hBEEF);
        @(posedge CP);
        #1 IN_VALID = 1'b0;
        repeat (2) @(posedge CP);
        #1 check("send_before_rst", {63'd0, Send_out}, 64'd1);
        #2 MR_N = 1'b0;
        #1;
        check("rst_mid_send", {63'd0, Send_out}, 64'd0);
        check("rst_mid_occ", {57'd0, OCC}, 64'd0);
        check("rst_mid_err", {63'd0, ERR}, 64'd0);
        check("rst_mid_wre", {63'd0, WR_E}, 64'd0);
        repeat (3) @(negedge CP);
        MR_N = 1'b1;
        model_clear();
        repeat (10) @(negedge CP);
        check("rst_rel_ready", {63'd0, IN_READY}, 64'd1);

        // Fill every address, then drain with partners
        for (int i = 0; i < 64; i++) send_token(mk(7'(i), 1'b0, 1'b1, 16'(i)));
        check("fill_occ", {57'd0, OCC}, 64'd64);
        for (int i = 0; i < 64; i++) send_token(mk(7'(i), 1'b1, 1'b1, 16'(i + 100)));
        check("drain_occ", {57'd0, OCC}, 64'd0);
        // Every address must now accept a fresh first operand
        for (int i = 0; i < 64; i += 9) send_token(mk(7'(i) | 7'h40, 1'b1, 1'b1, 16'hC0DE));

        // Randomized traffic over a small address window to force all cases
        for (int k = 0; k < 150; k++) begin
            pkt         = {$urandom, $urandom};
            pkt[25:20]  = 6'($urandom_range(0, 7));
            pkt[18]     = ($urandom_range(0, 3) != 0);
            send_token(pkt);
            repeat ($urandom_range(0, 2)) @(negedge CP);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
